// File: rtl/l2_line_responder.sv
// l2_line_responder: direct-mapped, write-back, write-allocate L2 line cache.
// Serves one L1 line request at a time; misses go to physical memory through
// a pmem read/write/resp handshake.
//
// Handshake semantics (both sides): a requester raises read or write and
// holds it, together with address and data, until the responder returns a
// single-cycle resp pulse; the request is considered consumed on that pulse.
module l2_line_responder #(
   parameter int SETS   = 8,
   parameter int ADDR_W = 16,
   parameter int LINE_W = 128
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [LINE_W-1:0] mem_wdata,
   output logic [LINE_W-1:0] mem_rdata,
   output logic              mem_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_addr,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   localparam int IDX_W  = $clog2(SETS);
   localparam int LADR_W = ADDR_W - 4;
   localparam int TAG_W  = ADDR_W - 4 - IDX_W;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_CHECK     = 3'd1,
      S_WRITEBACK = 3'd2,
      S_FILL      = 3'd3,
      S_DONE      = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic                req_wr_q, req_wr_d;
   logic [LADR_W-1:0]   req_line_q, req_line_d;
   logic [LINE_W-1:0]   req_wdata_q, req_wdata_d;
   logic [SETS-1:0]     valid_q, valid_d;
   logic [SETS-1:0]     dirty_q, dirty_d;

   // Line storage and tags carry no reset; valid bits qualify them.
   logic [LINE_W-1:0]   data_q [SETS];
   logic [TAG_W-1:0]    tag_q  [SETS];

   logic                line_we;
   logic [LINE_W-1:0]   line_wdata;

   logic [IDX_W-1:0]    idx;
   logic [TAG_W-1:0]    req_tag;
   logic                hit;

   // Byte-offset bits select nothing inside a full-line transfer.
   logic                unused_offset;
   assign unused_offset = ^mem_addr[3:0];

   assign idx     = req_line_q[IDX_W-1:0];
   assign req_tag = req_line_q[LADR_W-1:IDX_W];
   assign hit     = valid_q[idx] && (tag_q[idx] == req_tag);

   // Next-state, array write controls and all outputs for the request FSM.
   always_comb begin
      state_d     = state_q;
      req_wr_d    = req_wr_q;
      req_line_d  = req_line_q;
      req_wdata_d = req_wdata_q;
      valid_d     = valid_q;
      dirty_d     = dirty_q;
      line_we     = 1'b0;
      line_wdata  = req_wdata_q;
      mem_resp    = 1'b0;
      mem_rdata   = '0;
      pmem_read   = 1'b0;
      pmem_write  = 1'b0;
      pmem_addr   = '0;
      pmem_wdata  = '0;

      case (state_q)
         S_IDLE: begin
            if (mem_read || mem_write) begin
               // Read wins when both strobes are raised together.
               req_wr_d    = !mem_read;
               req_line_d  = mem_addr[ADDR_W-1:4];
               req_wdata_d = mem_wdata;
               state_d     = S_CHECK;
            end
         end

         S_CHECK: begin
            if (!req_wr_q) begin
               if (hit) begin
                  mem_resp  = 1'b1;
                  mem_rdata = data_q[idx];
                  state_d   = S_DONE;
               end else if (valid_q[idx] && dirty_q[idx]) begin
                  state_d = S_WRITEBACK;
               end else begin
                  state_d = S_FILL;
               end
            end else begin
               // Full-line write: no fill needed unless a dirty victim blocks it.
               if (hit || !valid_q[idx] || !dirty_q[idx]) begin
                  line_we      = 1'b1;
                  line_wdata   = req_wdata_q;
                  valid_d[idx] = 1'b1;
                  dirty_d[idx] = 1'b1;
                  mem_resp     = 1'b1;
                  state_d      = S_DONE;
               end else begin
                  state_d = S_WRITEBACK;
               end
            end
         end

         S_WRITEBACK: begin
            pmem_write = 1'b1;
            pmem_addr  = {tag_q[idx], idx, 4'b0000};
            pmem_wdata = data_q[idx];
            if (pmem_resp) begin
               dirty_d[idx] = 1'b0;
               state_d      = req_wr_q ? S_CHECK : S_FILL;
            end
         end

         S_FILL: begin
            pmem_read = 1'b1;
            pmem_addr = {req_tag, idx, 4'b0000};
            if (pmem_resp) begin
               line_we      = 1'b1;
               line_wdata   = pmem_rdata;
               valid_d[idx] = 1'b1;
               dirty_d[idx] = 1'b0;
               state_d      = S_CHECK;
            end
         end

         S_DONE: begin
            // One dead cycle so a request still held by the L1 is not re-served.
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // FSM state, captured request and per-line valid/dirty bits.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         req_wr_q    <= 1'b0;
         req_line_q  <= '0;
         req_wdata_q <= '0;
         valid_q     <= '0;
         dirty_q     <= '0;
      end else begin
         state_q     <= state_d;
         req_wr_q    <= req_wr_d;
         req_line_q  <= req_line_d;
         req_wdata_q <= req_wdata_d;
         valid_q     <= valid_d;
         dirty_q     <= dirty_d;
      end
   end

   // Line data and tag array update on write-allocate or fill.
   always_ff @(posedge clk) begin
      if (rst_n && line_we) begin
         data_q[idx] <= line_wdata;
         tag_q[idx]  <= req_tag;
      end
   end

endmodule

// File: tb/tb_l2_line_responder.sv
// tb_l2_line_responder: directed-vector bench for the L2 line responder.
// A driver issues L1 requests, a pmem responder model serves memory traffic,
// and a monitor compares every mem_resp against the expected queue.
module tb_l2_line_responder;

   localparam int AW = 16;
   localparam int LW = 128;

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [LW-1:0] data;
      logic [LW-1:0] fill;
      logic          respond;
   } pexp_t;

   logic          clk;
   logic          rst_n;
   logic          mem_read;
   logic          mem_write;
   logic [AW-1:0] mem_addr;
   logic [LW-1:0] mem_wdata;
   logic [LW-1:0] mem_rdata;
   logic          mem_resp;
   logic          pmem_read;
   logic          pmem_write;
   logic [AW-1:0] pmem_addr;
   logic [LW-1:0] pmem_wdata;
   logic [LW-1:0] pmem_rdata;
   logic          pmem_resp;

   logic [LW-1:0] exp_q[$];
   bit            exp_chk_q[$];
   pexp_t         pexp_q[$];

   int n_vec = 0;
   int n_err = 0;

   l2_line_responder #(.SETS(8), .ADDR_W(AW), .LINE_W(LW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_resp   (mem_resp),
      .pmem_read  (pmem_read),
      .pmem_write (pmem_write),
      .pmem_addr  (pmem_addr),
      .pmem_wdata (pmem_wdata),
      .pmem_rdata (pmem_rdata),
      .pmem_resp  (pmem_resp)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: got still running expected finished");
      $fatal(1, "simulation time limit");
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_pmem(input logic wr, input logic [AW-1:0] addr, input logic [LW-1:0] data,
                            input logic [LW-1:0] fill, input logic respond);
      pexp_t e;
      e.wr = wr; e.addr = addr; e.data = data; e.fill = fill; e.respond = respond;
      pexp_q.push_back(e);
   endtask

   // Issue one request (call just after a negedge); waits for mem_resp,
   // checks latency in cycles when exp_lat > 0, then idles two cycles.
   task automatic do_req(input logic rd, input logic wr, input logic [AW-1:0] addr,
                         input logic [LW-1:0] wd, input logic [LW-1:0] exp_rd, input int exp_lat);
      int  cyc;
      bit  got;
      exp_q.push_back(exp_rd);
      exp_chk_q.push_back(rd);
      mem_read  = rd;
      mem_write = wr;
      mem_addr  = addr;
      mem_wdata = wd;
      cyc = 0;
      got = 0;
      while (!got && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (mem_resp) got = 1;
      end
      if (!got) begin
         check("resp_timeout", LW'(0), LW'(1));
         void'(exp_q.pop_back());
         void'(exp_chk_q.pop_back());
      end else if (exp_lat > 0) begin
         check("resp_latency", LW'(cyc), LW'(exp_lat));
      end
      mem_read  = 1'b0;
      mem_write = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   // ---------------- monitor / scoreboard ----------------
   logic [LW-1:0] mon_d;
   bit            mon_c;

   always @(negedge clk) begin
      if (mem_resp) begin
         if (exp_q.size() == 0) begin
            check("unexpected_mem_resp", LW'(mem_resp), LW'(0));
         end else begin
            mon_d = exp_q.pop_front();
            mon_c = exp_chk_q.pop_front();
            if (mon_c) check("mem_rdata", mem_rdata, mon_d);
         end
      end else if (mem_rdata !== '0) begin
         check("mem_rdata_idle_zero", mem_rdata, '0);
      end
      if (pmem_read && pmem_write) begin
         check("pmem_both_strobes", LW'(1), LW'(0));
      end
   end

   // ---------------- pmem responder model ----------------
   initial begin
      pexp_t e;
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      @(negedge clk);
      forever begin
         if (!(pmem_read || pmem_write)) begin
            @(negedge clk);
         end else if (pexp_q.size() == 0) begin
            check("unexpected_pmem_strobe", LW'({pmem_read, pmem_write}), LW'(0));
            for (int k = 0; k < 50 && (pmem_read || pmem_write); k++) @(negedge clk);
         end else begin
            e = pexp_q.pop_front();
            check("pmem_op_is_write", LW'(pmem_write), LW'(e.wr));
            check("pmem_addr", LW'(pmem_addr), LW'(e.addr));
            if (e.wr) check("pmem_wdata", pmem_wdata, e.data);
            if (e.respond) begin
               for (int k = 0; k < 2; k++) begin
                  @(negedge clk);
                  check("pmem_addr_stable", LW'(pmem_addr), LW'(e.addr));
                  check("pmem_strobe_held", LW'(e.wr ? pmem_write : pmem_read), LW'(1));
               end
               pmem_rdata = e.fill;
               pmem_resp  = 1'b1;
               @(negedge clk);
               pmem_resp  = 1'b0;
               pmem_rdata = '0;
            end else begin
               for (int k = 0; k < 50 && (pmem_read || pmem_write); k++) @(negedge clk);
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   initial begin
      int n_resp;
      int resp_at;
      int k;
      rst_n     = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      repeat (3) @(negedge clk);

      // Reset state: every output low.
      check("rst_mem_resp",   LW'(mem_resp), LW'(0));
      check("rst_mem_rdata",  mem_rdata, '0);
      check("rst_pmem_read",  LW'(pmem_read), LW'(0));
      check("rst_pmem_write", LW'(pmem_write), LW'(0));
      check("rst_pmem_addr",  LW'(pmem_addr), LW'(0));
      check("rst_pmem_wdata", pmem_wdata, '0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: cold read fills from memory, resp one cycle after pmem_resp.
      push_pmem(1'b0, 16'h1230, '0, {16{8'hA5}}, 1'b1);
      do_req(1'b1, 1'b0, 16'h1230, '0, {16{8'hA5}}, 5);

      // 2: different offset, same line -> hit.
      do_req(1'b1, 1'b0, 16'h123F, '0, {16{8'hA5}}, 1);

      // 5: request held past resp -> one resp per IDLE entry, none in DONE.
      exp_q.push_back({16{8'hA5}}); exp_chk_q.push_back(1'b1);
      exp_q.push_back({16{8'hA5}}); exp_chk_q.push_back(1'b1);
      mem_read = 1'b1;
      mem_addr = 16'h1230;
      k = 0;
      while (!mem_resp && k < 20) begin @(negedge clk); k++; end
      check("held_first_latency", LW'(k), LW'(1));
      n_resp  = 0;
      resp_at = 0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         if (mem_resp) begin n_resp++; resp_at = c; end
      end
      check("held_resp_count", LW'(n_resp), LW'(1));
      check("held_resp_cycle", LW'(resp_at), LW'(3));
      mem_read = 1'b0;
      @(negedge clk);
      @(negedge clk);

      // 3: write hit, then conflicting read forces writeback then fill.
      do_req(1'b0, 1'b1, 16'h1230, {16{8'h11}}, '0, 1);
      push_pmem(1'b1, 16'h1230, {16{8'h11}}, '0, 1'b1);
      push_pmem(1'b0, 16'h5230, '0, {16{8'h5A}}, 1'b1);
      do_req(1'b1, 1'b0, 16'h5230, '0, {16{8'h5A}}, 8);

      // Write miss over a clean victim: no memory traffic.
      do_req(1'b0, 1'b1, 16'h7230, {16{8'h77}}, '0, 1);

      // 4: write miss to invalid set, read back as hit.
      do_req(1'b0, 1'b1, 16'h0040, {16{8'h44}}, '0, 1);
      do_req(1'b1, 1'b0, 16'h0040, '0, {16{8'h44}}, 1);

      // Read and write together: read wins, line untouched.
      do_req(1'b1, 1'b1, 16'h0040, {16{8'h99}}, {16{8'h44}}, 1);
      do_req(1'b1, 1'b0, 16'h0047, '0, {16{8'h44}}, 1);

      // Write miss over a dirty victim: writeback, then allocate.
      push_pmem(1'b1, 16'h0040, {16{8'h44}}, '0, 1'b1);
      do_req(1'b0, 1'b1, 16'h0840, {16{8'h88}}, '0, 5);
      do_req(1'b1, 1'b0, 16'h0840, '0, {16{8'h88}}, 1);

      // 6: reset during writeback abandons it.
      push_pmem(1'b1, 16'h7230, {16{8'h77}}, '0, 1'b0);
      mem_read = 1'b1;
      mem_addr = 16'h1230;
      k = 0;
      while (!pmem_write && k < 20) begin @(negedge clk); k++; end
      check("wb_before_reset", LW'(pmem_write), LW'(1));
      rst_n    = 1'b0;
      mem_read = 1'b0;
      @(negedge clk);
      check("rst_mid_pmem_write", LW'(pmem_write), LW'(0));
      check("rst_mid_pmem_read",  LW'(pmem_read), LW'(0));
      check("rst_mid_mem_resp",   LW'(mem_resp), LW'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // After reset the set is invalid: plain fill, no writeback.
      push_pmem(1'b0, 16'h1230, '0, {16{8'hC3}}, 1'b1);
      do_req(1'b1, 1'b0, 16'h1230, '0, {16{8'hC3}}, 5);
      // Dirty data from before reset is gone: read misses without writeback.
      push_pmem(1'b0, 16'h0840, '0, {16{8'hE1}}, 1'b1);
      do_req(1'b1, 1'b0, 16'h0840, '0, {16{8'hE1}}, 5);

      repeat (5) @(negedge clk);
      check("exp_q_drained",  LW'(exp_q.size()), LW'(0));
      check("pexp_q_drained", LW'(pexp_q.size()), LW'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
